// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file and its writeback path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    localparam logic [AW-1:0] ZERO_REG = 5'd0;

    // One writeback request: destination register plus the value to write.
    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a force-requester-0 override.
// Latency: purely combinational; the pointer register lives in the caller.
// Backpressure: a non-granted requester simply sees no grant and keeps asking.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       force0,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // A single requester always wins; on contention, the override or a pointer
    // sitting at requester 1 hands the grant to requester 0, otherwise to 1.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            if (force0 || last_grant) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two writeback sources onto the single regfile write port, filters x0.
// Latency: a request accepted at posedge N drives we3/wa3/wd3 during cycle N+1.
// Backpressure: reqN_ready is combinational; the loser holds its request until granted.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int CW   = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_addr,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_addr,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    output logic            we3,
    output logic [AW-1:0]   wa3,
    output logic [XLEN-1:0] wd3,
    output logic            last_grant,
    output logic [CW-1:0]   wr_count0,
    output logic [CW-1:0]   wr_count1
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [1:0]            req_vec;
    logic                  same_addr;
    logic [1:0]            gnt;
    regfile_pkg::wb_req_t  win;

    logic                  we3_q, we3_d;
    logic [AW-1:0]         wa3_q, wa3_d;
    logic [XLEN-1:0]       wd3_q, wd3_d;
    logic                  last_grant_q, last_grant_d;
    logic [CW-1:0]         wr_count0_q, wr_count0_d;
    logic [CW-1:0]         wr_count1_q, wr_count1_d;

    // Requests are masked during reset so nothing is accepted while the
    // state is being cleared; same-address contention forces the older source.
    assign req_vec   = {req1_valid, req0_valid} & {2{reset_n}};
    assign same_addr = (req0_addr == req1_addr);

    rr_arb2 u_arb (
        .req        (req_vec),
        .force0     (same_addr),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // Select the winning request's payload.
    always_comb begin
        win.addr = req0_addr;
        win.data = req0_data;
        if (gnt[1]) begin
            win.addr = req1_addr;
            win.data = req1_data;
        end
    end

    // Next state: load the winner into the write stage (x0 accepted but not
    // written), move the pointer to the winner, bump saturating counters.
    always_comb begin
        we3_d        = 1'b0;
        wa3_d        = wa3_q;
        wd3_d        = wd3_q;
        last_grant_d = last_grant_q;
        wr_count0_d  = wr_count0_q;
        wr_count1_d  = wr_count1_q;
        if (|gnt) begin
            we3_d        = (win.addr != regfile_pkg::ZERO_REG);
            wa3_d        = win.addr;
            wd3_d        = win.data;
            last_grant_d = gnt[1];
        end
        if (gnt[0] && (wr_count0_q != CNT_MAX)) begin
            wr_count0_d = wr_count0_q + {{(CW-1){1'b0}}, 1'b1};
        end
        if (gnt[1] && (wr_count1_q != CNT_MAX)) begin
            wr_count1_d = wr_count1_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // State registers; reset drops any pending write and points the
    // round-robin at requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            we3_q        <= 1'b0;
            wa3_q        <= '0;
            wd3_q        <= '0;
            last_grant_q <= 1'b1;
            wr_count0_q  <= '0;
            wr_count1_q  <= '0;
        end else begin
            we3_q        <= we3_d;
            wa3_q        <= wa3_d;
            wd3_q        <= wd3_d;
            last_grant_q <= last_grant_d;
            wr_count0_q  <= wr_count0_d;
            wr_count1_q  <= wr_count1_d;
        end
    end

    assign we3        = we3_q;
    assign wa3        = wa3_q;
    assign wd3        = wd3_q;
    assign last_grant = last_grant_q;
    assign wr_count0  = wr_count0_q;
    assign wr_count1  = wr_count1_q;

endmodule
